// File: rtl/bip_sequencer.sv
// rtl/bip_sequencer.sv - BIP instruction sequencer: PC, fetch/exec FSM, decode to datapath strobes
module bip_sequencer #(
  parameter int AB = 11,
  parameter int DB = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DB-1:0] Instr,
  output logic [AB-1:0] Addr,
  output logic [AB-1:0] Operand,
  output logic [1:0]    SelA,
  output logic          SelB,
  output logic          Op,
  output logic          WrAcc,
  output logic          WrRam,
  output logic          RdRam,
  output logic          busy,
  output logic          halted,
  output logic          illegal,
  output logic [15:0]   instr_count
);

  localparam int OPW = DB - AB;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AB-1:0] pc_q, pc_d;
  logic [15:0]   count_q, count_d;
  logic          illegal_q, illegal_d;
  logic          retire;
  logic [OPW-1:0] opcode;

  assign opcode      = Instr[DB-1:AB];
  assign Addr        = pc_q;
  assign busy        = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign halted      = (state_q == S_HALT);
  assign illegal     = illegal_q;
  assign instr_count = count_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    count_d   = count_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    Operand   = '0;
    SelA      = 2'd0;
    SelB      = 1'b0;
    Op        = 1'b0;
    WrAcc     = 1'b0;
    WrRam     = 1'b0;
    RdRam     = 1'b0;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d   = S_FETCH;
          pc_d      = '0;
          count_d   = '0;
          illegal_d = 1'b0;
        end
      end
      S_FETCH: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        Operand = Instr[AB-1:0];
        retire  = 1'b1;
        case (opcode)
          OPW'(0): begin
            retire  = 1'b0;
            state_d = S_HALT;
          end
          OPW'(1): WrRam = 1'b1;
          OPW'(2): begin
            RdRam = 1'b1;
            SelA  = 2'd0;
            WrAcc = 1'b1;
          end
          OPW'(3): begin
            SelA  = 2'd1;
            WrAcc = 1'b1;
          end
          OPW'(4): begin
            RdRam = 1'b1;
            SelA  = 2'd2;
            WrAcc = 1'b1;
          end
          OPW'(5): begin
            SelB  = 1'b1;
            SelA  = 2'd2;
            WrAcc = 1'b1;
          end
          OPW'(6): begin
            RdRam = 1'b1;
            SelA  = 2'd2;
            Op    = 1'b1;
            WrAcc = 1'b1;
          end
          OPW'(7): begin
            SelB  = 1'b1;
            SelA  = 2'd2;
            Op    = 1'b1;
            WrAcc = 1'b1;
          end
          default: begin
            retire    = 1'b0;
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end
        endcase
        if (retire) begin
          // PC wraps naturally at AB bits; the retired count saturates instead
          pc_d    = pc_q + AB'(1);
          count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

endmodule
